// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage OpenMIPS core: stall arbitration, exception flush/redirect,
// post-flush holdoff and a sticky stall watchdog. Define PIPE_CTRL_PERF_EN to build the perf counters.
module pipe_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [3:0]  HOLDOFF    = 4'd2,
  parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_o,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  hold_cnt_r;
  logic [3:0]  hold_cnt_nxt_s;
  logic [15:0] wd_cnt_r;
  logic        wdog_r;
  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] new_pc_s;

  function automatic logic [31:0] sel_new_pc(input logic [31:0] exc, input logic [31:0] epc);
    logic [31:0] pc;
    case (exc)
      32'h0000_0001:                                           pc = INT_VECTOR;
      32'h0000_0008, 32'h0000_000a, 32'h0000_000c, 32'h0000_000d: pc = EXC_VECTOR;
      32'h0000_000e:                                           pc = epc;
      default:                                                 pc = EXC_VECTOR;
    endcase
    return pc;
  endfunction

  // Deeper stages freeze everything upstream of themselves; IF and ID share one pattern.
  function automatic logic [5:0] stall_prio(input logic r_if, input logic r_id,
                                            input logic r_ex, input logic r_mem);
    logic [5:0] v;
    if (r_mem) begin
      v = 6'b011111;
    end else if (r_ex) begin
      v = 6'b001111;
    end else if (r_id || r_if) begin
      v = 6'b000111;
    end else begin
      v = 6'b000000;
    end
    return v;
  endfunction

  // Next-state, flush/redirect and stall decode
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    flush_s        = 1'b0;
    new_pc_s       = 32'h0000_0000;
    stall_s        = 6'b000000;
    case (state_r)
      ST_IDLE: begin
        if (excepttype_i != 32'h0000_0000) begin
          flush_s        = 1'b1;
          new_pc_s       = sel_new_pc(excepttype_i, cp0_epc_i);
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = HOLDOFF - 4'd1;
        end else begin
          stall_s = stall_prio(stallreq_from_if, stallreq_from_id,
                               stallreq_from_ex, stallreq_from_mem);
        end
      end
      ST_HOLD: begin
        stall_s = stall_prio(stallreq_from_if, stallreq_from_id,
                             stallreq_from_ex, stallreq_from_mem);
        if (hold_cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        hold_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // State and holdoff counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end

  // Watchdog: count consecutive stalled cycles, latch the flag once the limit is hit
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= 16'd0;
      wdog_r   <= 1'b0;
    end else if (flush_s || (stall_s == 6'b000000)) begin
      wd_cnt_r <= 16'd0;
    end else if (wd_cnt_r == (WDOG_LIMIT - 16'd1)) begin
      wdog_r   <= 1'b1;
    end else begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Performance counters: stall count wraps, flush count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 16'd0;
    end else begin
      if (stall_s != 6'b000000) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (flush_s && (perf_flush_r != 16'hFFFF)) begin
        perf_flush_r <= perf_flush_r + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_flush_cnt = perf_flush_r;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 16'd0;
`endif

  assign stall  = stall_s;
  assign flush  = flush_s;
  assign new_pc = new_pc_s;
  assign wdog_o = wdog_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vectors, literal expectations and a
// cycle-level reference model compared on every falling edge.
module tb_pipe_ctrl;

  localparam logic [31:0] INT_V  = 32'h0000_0020;
  localparam logic [31:0] EXC_V  = 32'h0000_0040;
  localparam int          HOLD_N = 2;
  localparam int          WD_LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_o;
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit check_en = 1'b0;

  // reference model state
  int          ign_left  = 0;
  int          consec    = 0;
  bit          wd_flag   = 1'b0;
  logic [31:0] m_pstall  = 32'd0;
  int          m_pflush  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.WDOG_LIMIT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(s_if), .stallreq_from_id(s_id),
    .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .wdog_o(wdog_o),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit m_flush(input int ign, input logic [31:0] e);
    return (ign == 0) && (e != 32'd0);
  endfunction

  function automatic logic [31:0] m_pc(input bit f, input logic [31:0] e, input logic [31:0] p);
    if (!f) return 32'd0;
    if (e == 32'h1) return INT_V;
    if (e == 32'he) return p;
    return EXC_V;
  endfunction

  function automatic logic [5:0] m_stall(input bit f, input logic a, input logic b,
                                         input logic c, input logic d);
    if (f) return 6'd0;
    if (d) return 6'b011111;
    if (c) return 6'b001111;
    if (a || b) return 6'b000111;
    return 6'd0;
  endfunction

  // model update on each active edge, from the inputs of the closing cycle
  always @(posedge clk) begin
    bit         f;
    logic [5:0] st;
    f  = m_flush(ign_left, exc);
    st = m_stall(f, s_if, s_id, s_ex, s_mem);
    if (rst) begin
      ign_left <= 0;
      consec   <= 0;
      wd_flag  <= 1'b0;
      m_pstall <= 32'd0;
      m_pflush <= 0;
    end else begin
      ign_left <= f ? HOLD_N : ((ign_left > 0) ? ign_left - 1 : 0);
      consec   <= (st != 6'd0) ? consec + 1 : 0;
      if ((st != 6'd0) && (consec + 1 >= WD_LIM)) wd_flag <= 1'b1;
      if (st != 6'd0) m_pstall <= m_pstall + 32'd1;
      if (f && (m_pflush < 65535)) m_pflush <= m_pflush + 1;
    end
  end

  // compare DUT against model on every falling edge
  always @(negedge clk) begin
    if (check_en) begin
      bit          f;
      logic [31:0] es, ef;
      f = m_flush(ign_left, exc);
      chk("m_flush", {31'd0, flush}, {31'd0, f});
      chk("m_new_pc", new_pc, m_pc(f, exc, epc));
      chk("m_stall", {26'd0, stall}, {26'd0, m_stall(f, s_if, s_id, s_ex, s_mem)});
      chk("m_wdog", {31'd0, wdog_o}, {31'd0, wd_flag});
`ifdef PIPE_CTRL_PERF_EN
      es = m_pstall;
      ef = m_pflush;
`else
      es = 32'd0;
      ef = 32'd0;
`endif
      chk("m_perf_stall", perf_stall_cnt, es);
      chk("m_perf_flush", {16'd0, perf_flush_cnt}, ef);
    end
  end

  task automatic step(input logic r, input logic a, input logic b, input logic c,
                      input logic d, input logic [31:0] e);
    @(posedge clk);
    #1;
    rst = r; s_if = a; s_id = b; s_ex = c; s_mem = d; exc = e;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
    exc = 32'd0; epc = 32'd0;
    @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_wdog", {31'd0, wdog_o}, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_flush", {16'd0, perf_flush_cnt}, 32'd0);

    // stall priority
    step(0, 0, 1, 0, 0, 32'd0); chk("id_stall", {26'd0, stall}, 32'h07);
    step(0, 0, 1, 1, 0, 32'd0); chk("ex_stall", {26'd0, stall}, 32'h0f);
    step(0, 1, 1, 1, 1, 32'd0); chk("mem_stall", {26'd0, stall}, 32'h1f);
    step(0, 1, 0, 0, 0, 32'd0); chk("if_stall", {26'd0, stall}, 32'h07);

    // eret flush beats a mem stall, then holdoff, then interrupt
    epc = 32'h8000_0100;
    step(0, 0, 0, 0, 1, 32'he);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_pc", new_pc, 32'h8000_0100);
    chk("eret_stall", {26'd0, stall}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h1); chk("hold1_flush", {31'd0, flush}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h1); chk("hold2_flush", {31'd0, flush}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h1);
    chk("int_flush", {31'd0, flush}, 32'd1);
    chk("int_pc", new_pc, 32'h20);
    repeat (3) step(0, 0, 0, 0, 0, 32'd0);

    // watchdog
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0, 32'd0);
      chk("wdog_pre", {31'd0, wdog_o}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 32'd0); chk("wdog_set", {31'd0, wdog_o}, 32'd1);
    step(0, 0, 0, 0, 0, 32'd0); chk("wdog_sticky", {31'd0, wdog_o}, 32'd1);
    step(1, 0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 0, 32'd0); chk("wdog_clr", {31'd0, wdog_o}, 32'd0);

    // reset during the first HOLD cycle
    step(0, 0, 0, 0, 0, 32'h8); chk("exc8_pc", new_pc, 32'h40);
    step(1, 0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 0, 32'ha);
    chk("post_rst_flush", {31'd0, flush}, 32'd1);
    chk("post_rst_pc", new_pc, 32'h40);
    repeat (3) step(0, 0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 0, 32'h123); chk("other_exc_pc", new_pc, 32'h40);
    repeat (3) step(0, 0, 0, 0, 0, 32'd0);

    // perf counters: 5 stalled cycles and 2 flushes after reset
    step(1, 0, 0, 0, 0, 32'd0);
    repeat (5) step(0, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 0, 0, 32'hc);
    repeat (2) step(0, 0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 0, 32'hd);
    repeat (2) step(0, 0, 0, 0, 0, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'd5);
    chk("perf_flush", {16'd0, perf_flush_cnt}, 32'd2);
`else
    chk("perf_stall", perf_stall_cnt, 32'd0);
    chk("perf_flush", {16'd0, perf_flush_cnt}, 32'd0);
`endif

    @(posedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
